axi_burst_writer: RTL and testbench

- Fabric-side AXI4 write initiator: the opposite role to the existing PS-master/fabric-slave path; the fabric drives a PS HP slave port into DDR.
- Accepts a command (start address, word count) and streams 32-bit words from a valid/ready source into memory.
- Splits each command into INCR bursts that never exceed MAX_BURST beats and never cross a 4 KB boundary.
- Reports completion and an error flag once every write response has returned. Intended consumer: UART RX capture-to-DDR.

---
 rtl/axi_pkg.sv | 19 +
 rtl/axi_burst_writer_if.sv | 54 +++++
 rtl/burst_len_calc.sv | 34 +++
 rtl/axi_burst_writer.sv | 178 +++++++++++++++++
 tb/tb_axi_burst_writer.sv | 286 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/axi_pkg.sv
// Shared AXI encodings and the write-initiator state type.
package axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } wr_state_t;

  function automatic logic resp_is_err(input logic [1:0] resp);
    return (resp != AXI_RESP_OKAY);
  endfunction

endpackage

// File: rtl/axi_burst_writer_if.sv
// Command, source-stream, completion and AXI write-channel bundle for axi_burst_writer.
interface axi_burst_writer_if #(
  parameter int ADDR_W = 32,
  parameter int ID_W   = 6,
  parameter int CNT_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [ADDR_W-1:0] cmd_addr;
  logic [CNT_W-1:0]  cmd_count;

  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic [3:0]        in_strb;

  logic              done_valid;
  logic              done_err;
  logic              busy;

  logic              m_axi_awvalid;
  logic              m_axi_awready;
  logic [ADDR_W-1:0] m_axi_awaddr;
  logic [7:0]        m_axi_awlen;
  logic [2:0]        m_axi_awsize;
  logic [1:0]        m_axi_awburst;
  logic [ID_W-1:0]   m_axi_awid;
  logic              m_axi_wvalid;
  logic              m_axi_wready;
  logic [31:0]       m_axi_wdata;
  logic [3:0]        m_axi_wstrb;
  logic              m_axi_wlast;
  logic              m_axi_bvalid;
  logic              m_axi_bready;
  logic [1:0]        m_axi_bresp;
  logic [ID_W-1:0]   m_axi_bid;

  // The writer itself: AXI master, command/stream consumer.
  modport master (
    input  cmd_valid, cmd_addr, cmd_count, in_valid, in_data, in_strb,
           m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp, m_axi_bid,
    output cmd_ready, in_ready, done_valid, done_err, busy,
           m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awid, m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_bready
  );

  modport slave (
    output cmd_valid, cmd_addr, cmd_count, in_valid, in_data, in_strb,
           m_axi_awready, m_axi_wready, m_axi_bvalid, m_axi_bresp, m_axi_bid,
    input  cmd_ready, in_ready, done_valid, done_err, busy,
           m_axi_awvalid, m_axi_awaddr, m_axi_awlen, m_axi_awsize, m_axi_awburst,
           m_axi_awid, m_axi_wvalid, m_axi_wdata, m_axi_wstrb, m_axi_wlast, m_axi_bready
  );
endinterface

// File: rtl/burst_len_calc.sv
// Next burst length: min of words remaining, MAX_BURST and words left before the 4 KB boundary.
module burst_len_calc #(
  parameter int CNT_W     = 16,
  parameter int MAX_BURST = 16
) (
  input  logic [CNT_W-1:0] remaining_i,
  input  logic [11:0]      addr_lo_i,
  output logic [8:0]       len_o
);

  localparam int W = (CNT_W > 11) ? CNT_W : 11;

  logic [12:0]  bytes_to_4k_s;
  logic [W-1:0] rem_s;
  logic [W-1:0] bnd_s;
  logic [W-1:0] cap_s;
  logic [W-1:0] min1_s;
  logic [W-1:0] min2_s;
  logic         unused_s;

  // Three-way minimum in a common width; the result never exceeds MAX_BURST (<= 256).
  always_comb begin
    bytes_to_4k_s = 13'd4096 - {1'b0, addr_lo_i};
    rem_s         = W'(remaining_i);
    bnd_s         = W'(bytes_to_4k_s[12:2]);
    cap_s         = W'(MAX_BURST);
    min1_s        = (rem_s < cap_s) ? rem_s : cap_s;
    min2_s        = (min1_s < bnd_s) ? min1_s : bnd_s;
    len_o         = min2_s[8:0];
  end

  assign unused_s = ^{bytes_to_4k_s[1:0], min2_s[W-1:9]};

endmodule

// File: rtl/axi_burst_writer.sv
// Fabric-side AXI4 write initiator: splits a (start address, word count) command into
// 4 KB-safe INCR bursts fed from a valid/ready word stream, one burst outstanding at a time.
module axi_burst_writer
  import axi_pkg::*;
#(
  parameter int ADDR_W    = 32,
  parameter int ID_W      = 6,
  parameter int MAX_BURST = 16,
  parameter int CNT_W     = 16
) (
  input  logic               clk,
  input  logic               rst,
  axi_burst_writer_if.master bus
);

  wr_state_t         state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic [7:0]        beat_q, beat_d;
  logic [7:0]        awlen_q, awlen_d;
  logic              awvalid_q, awvalid_d;
  logic              err_q, err_d;
  logic              done_q, done_d;
  logic              done_err_q, done_err_d;

  logic [8:0]        len_s;
  logic [8:0]        burst_beats_s;
  logic [10:0]       burst_bytes_s;
  logic              wlast_s;
  logic              unused_s;

  burst_len_calc #(
    .CNT_W     (CNT_W),
    .MAX_BURST (MAX_BURST)
  ) u_len (
    .remaining_i (rem_q),
    .addr_lo_i   (addr_q[11:0]),
    .len_o       (len_s)
  );

  assign burst_beats_s = {1'b0, awlen_q} + 9'd1;
  assign burst_bytes_s = {burst_beats_s, 2'b00};
  assign wlast_s       = (beat_q == awlen_q);

  assign bus.m_axi_awvalid = awvalid_q;
  assign bus.m_axi_awaddr  = addr_q;
  assign bus.m_axi_awlen   = awlen_q;
  assign bus.m_axi_awsize  = AXI_SIZE_4B;
  assign bus.m_axi_awburst = AXI_BURST_INCR;
  assign bus.m_axi_awid    = {ID_W{1'b0}};
  assign bus.done_valid    = done_q;
  assign bus.done_err      = done_err_q;
  assign bus.busy          = (state_q != ST_IDLE);
  assign unused_s          = ^{bus.cmd_addr[1:0], bus.m_axi_bid};

  // Next-state, datapath updates and handshake outputs.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    rem_d      = rem_q;
    beat_d     = beat_q;
    awlen_d    = awlen_q;
    awvalid_d  = awvalid_q;
    err_d      = err_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;

    bus.cmd_ready    = 1'b0;
    bus.in_ready     = 1'b0;
    bus.m_axi_wvalid = 1'b0;
    bus.m_axi_wdata  = 32'h0000_0000;
    bus.m_axi_wstrb  = 4'h0;
    bus.m_axi_wlast  = 1'b0;
    bus.m_axi_bready = 1'b0;

    case (state_q)
      ST_IDLE: begin
        bus.cmd_ready = 1'b1;
        if (bus.cmd_valid) begin
          addr_d = {bus.cmd_addr[ADDR_W-1:2], 2'b00};
          rem_d  = bus.cmd_count;
          err_d  = 1'b0;
          if (bus.cmd_count == {CNT_W{1'b0}}) begin
            done_d     = 1'b1;
            done_err_d = 1'b0;
          end else begin
            state_d   = ST_ADDR;
            awvalid_d = 1'b0;
          end
        end else begin
          state_d = ST_IDLE;
        end
      end

      // First ADDR cycle only registers the length; awvalid rises the cycle after.
      ST_ADDR: begin
        if (!awvalid_q) begin
          awlen_d   = 8'(len_s - 9'd1);
          awvalid_d = 1'b1;
        end else if (bus.m_axi_awready) begin
          awvalid_d = 1'b0;
          beat_d    = 8'd0;
          state_d   = ST_DATA;
        end else begin
          awvalid_d = 1'b1;
        end
      end

      ST_DATA: begin
        bus.m_axi_wvalid = bus.in_valid;
        bus.in_ready     = bus.m_axi_wready;
        bus.m_axi_wdata  = bus.in_data;
        bus.m_axi_wstrb  = bus.in_strb;
        bus.m_axi_wlast  = wlast_s;
        if (bus.in_valid && bus.m_axi_wready) begin
          beat_d = beat_q + 8'd1;
          if (wlast_s) begin
            state_d = ST_RESP;
            addr_d  = addr_q + ADDR_W'(burst_bytes_s);
            rem_d   = rem_q - CNT_W'(burst_beats_s);
          end else begin
            state_d = ST_DATA;
          end
        end else begin
          beat_d = beat_q;
        end
      end

      ST_RESP: begin
        bus.m_axi_bready = 1'b1;
        if (bus.m_axi_bvalid) begin
          err_d = err_q | resp_is_err(bus.m_axi_bresp);
          if (rem_q == {CNT_W{1'b0}}) begin
            done_d     = 1'b1;
            done_err_d = err_q | resp_is_err(bus.m_axi_bresp);
            state_d    = ST_IDLE;
          end else begin
            awvalid_d = 1'b0;
            state_d   = ST_ADDR;
          end
        end else begin
          state_d = ST_RESP;
        end
      end

      default: begin
        state_d   = ST_IDLE;
        awvalid_d = 1'b0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any burst in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      addr_q     <= {ADDR_W{1'b0}};
      rem_q      <= {CNT_W{1'b0}};
      beat_q     <= 8'd0;
      awlen_q    <= 8'd0;
      awvalid_q  <= 1'b0;
      err_q      <= 1'b0;
      done_q     <= 1'b0;
      done_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      rem_q      <= rem_d;
      beat_q     <= beat_d;
      awlen_q    <= awlen_d;
      awvalid_q  <= awvalid_d;
      err_q      <= err_d;
      done_q     <= done_d;
      done_err_q <= done_err_d;
    end
  end

endmodule

// File: tb/tb_axi_burst_writer.sv
// Scoreboard bench for axi_burst_writer: commands push expected AW/W/done items built from
// a burst-splitting model; a negedge monitor pops and compares on every DUT handshake.
module tb_axi_burst_writer;
  import axi_pkg::*;

  localparam int ADDR_W    = 32;
  localparam int ID_W      = 6;
  localparam int CNT_W     = 16;
  localparam int MAX_BURST = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi_burst_writer_if #(.ADDR_W(ADDR_W), .ID_W(ID_W), .CNT_W(CNT_W)) bus ();

  axi_burst_writer #(
    .ADDR_W(ADDR_W), .ID_W(ID_W), .MAX_BURST(MAX_BURST), .CNT_W(CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [39:0] aw_exp[$];
  logic [36:0] w_exp[$];
  logic [35:0] src_q[$];
  logic [1:0]  bresp_q[$];
  logic        done_exp[$];

  int n_checks = 0;
  int n_pass   = 0;
  int w_seen   = 0;
  bit aw_open  = 1'b0;
  bit rnd_ready  = 1'b0;
  bit rnd_src    = 1'b0;
  bit hold_w_low = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Source stream: presents queued words, optionally with random gaps.
  initial begin
    bit hs;
    bus.in_valid = 1'b0; bus.in_data = 32'h0; bus.in_strb = 4'h0;
    forever begin
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk); #1;
      if (rst) begin
        src_q.delete();
        bus.in_valid = 1'b0;
      end else begin
        if (hs && src_q.size() > 0) src_q.delete(0);
        if (src_q.size() > 0 && (!rnd_src || $urandom_range(0, 2) != 0)) begin
          bus.in_valid = 1'b1;
          {bus.in_strb, bus.in_data} = src_q[0];
        end else begin
          bus.in_valid = 1'b0;
          bus.in_data  = $urandom;
        end
      end
    end
  end

  // AW/W ready generation.
  initial begin
    bus.m_axi_awready = 1'b0; bus.m_axi_wready = 1'b0;
    forever begin
      @(posedge clk); #1;
      bus.m_axi_awready = !rnd_ready || ($urandom_range(0, 3) != 0);
      bus.m_axi_wready  = !hold_w_low && (!rnd_ready || ($urandom_range(0, 3) != 0));
    end
  end

  // Write-response slave: one B per completed burst, response taken from the plan.
  initial begin
    bit wl_hs, b_hs;
    int pending;
    pending = 0;
    bus.m_axi_bvalid = 1'b0; bus.m_axi_bresp = 2'b00; bus.m_axi_bid = {ID_W{1'b0}};
    forever begin
      @(negedge clk);
      wl_hs = bus.m_axi_wvalid && bus.m_axi_wready && bus.m_axi_wlast;
      b_hs  = bus.m_axi_bvalid && bus.m_axi_bready;
      @(posedge clk); #1;
      if (rst) begin
        pending = 0;
        bus.m_axi_bvalid = 1'b0;
      end else begin
        if (wl_hs) pending++;
        if (b_hs) begin bus.m_axi_bvalid = 1'b0; pending--; end
        if (!bus.m_axi_bvalid && pending > 0 && (!rnd_ready || $urandom_range(0, 2) == 0)) begin
          bus.m_axi_bvalid = 1'b1;
          bus.m_axi_bresp  = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
          bus.m_axi_bid    = ID_W'($urandom);
        end
      end
    end
  end

  // Monitor: compares every AW, W and done event against the scoreboard queues.
  initial begin
    logic [39:0] ea;
    logic [36:0] ew;
    forever begin
      @(negedge clk);
      if (rst) begin
        aw_open = 1'b0;
      end else begin
        if (bus.m_axi_wvalid) chk("w_after_aw", 64'(aw_open), 64'(1));
        if (bus.busy) chk("cmd_ready_busy", 64'(bus.cmd_ready), 64'(0));
        if (bus.m_axi_awvalid && bus.m_axi_awready) begin
          if (aw_exp.size() == 0) begin
            n_checks++;
            $display("FAIL aw_unexpected: got awaddr 0x%0h awlen %0d, expected no AW", bus.m_axi_awaddr, bus.m_axi_awlen);
          end else begin
            ea = aw_exp.pop_front();
            chk("awaddr", 64'(bus.m_axi_awaddr), 64'(ea[39:8]));
            chk("awlen", 64'(bus.m_axi_awlen), 64'(ea[7:0]));
            chk("aw_fixed", 64'({bus.m_axi_awsize, bus.m_axi_awburst, bus.m_axi_awid}),
                64'({3'b010, 2'b01, 6'd0}));
          end
          aw_open = 1'b1;
        end
        if (bus.m_axi_wvalid && bus.m_axi_wready) begin
          w_seen++;
          if (w_exp.size() == 0) begin
            n_checks++;
            $display("FAIL w_unexpected: got wdata 0x%0h, expected no W beat", bus.m_axi_wdata);
          end else begin
            ew = w_exp.pop_front();
            chk("w_beat", 64'({bus.m_axi_wlast, bus.m_axi_wstrb, bus.m_axi_wdata}), 64'(ew));
          end
          if (bus.m_axi_wlast) aw_open = 1'b0;
        end
        if (bus.done_valid) begin
          if (done_exp.size() == 0) begin
            n_checks++;
            $display("FAIL done_unexpected: got done_valid 1, expected none");
          end else begin
            chk("done_err", 64'(bus.done_err), 64'(done_exp.pop_front()));
          end
        end
      end
    end
  end

  // Builds the expected bursts from the command, queues them, then offers the command.
  task automatic issue(input logic [31:0] addr, input int count, input int err_idx,
                       input bit rand_err, input bit lat_chk);
    logic [31:0] a;
    logic [31:0] d;
    logic [3:0]  s;
    logic [1:0]  br;
    logic        err;
    int rem, len, room, bi;
    a = addr & 32'hFFFF_FFFC; rem = count; bi = 0; err = 1'b0;
    while (rem > 0) begin
      room = (4096 - int'(a % 32'd4096)) / 4;
      len = rem;
      if (len > MAX_BURST) len = MAX_BURST;
      if (len > room) len = room;
      aw_exp.push_back({a, 8'(len - 1)});
      if (bi == err_idx) br = 2'b10;
      else if (rand_err && $urandom_range(0, 5) == 0) br = 2'($urandom_range(1, 3));
      else br = 2'b00;
      bresp_q.push_back(br);
      err = err | (br != 2'b00);
      for (int k = 0; k < len; k++) begin
        d = $urandom; s = 4'($urandom);
        src_q.push_back({s, d});
        w_exp.push_back({(k == len - 1), s, d});
      end
      a = a + 32'(len * 4);
      rem = rem - len;
      bi++;
    end
    done_exp.push_back(err);
    bus.cmd_valid = 1'b1; bus.cmd_addr = addr; bus.cmd_count = 16'(count);
    @(posedge clk); #2;
    bus.cmd_valid = 1'b0; bus.cmd_addr = $urandom; bus.cmd_count = 16'($urandom);
    if (lat_chk) begin
      @(negedge clk);
      chk("lat1_awvalid", 64'(bus.m_axi_awvalid), 64'(0));
      chk("lat1_busy", 64'(bus.busy), 64'(count != 0));
      chk("lat1_done", 64'(bus.done_valid), 64'(count == 0));
      @(negedge clk);
      chk("lat2_awvalid", 64'(bus.m_axi_awvalid), 64'(count != 0));
      chk("lat2_done", 64'(bus.done_valid), 64'(0));
      @(posedge clk); #2;
    end
  endtask

  task automatic wait_done(input string name);
    int t;
    t = 0;
    while (done_exp.size() != 0 && t < 4000) begin
      @(posedge clk); #2;
      t++;
    end
    n_checks++;
    if (done_exp.size() == 0) n_pass++;
    else $display("FAIL %s_timeout: got %0d pending completions, expected 0", name, done_exp.size());
    chk({name, "_aw_drained"}, 64'(aw_exp.size()), 64'(0));
    chk({name, "_w_drained"}, 64'(w_exp.size()), 64'(0));
  endtask

  task automatic wait_beats(input int target);
    int t;
    t = 0;
    while (w_seen < target && t < 500) begin
      @(posedge clk); #2;
      t++;
    end
    n_checks++;
    if (w_seen >= target) n_pass++;
    else $display("FAIL beat_wait: got %0d beats, expected %0d", w_seen, target);
  endtask

  initial begin
    logic [31:0] ra;
    #500000;
    $display("FAIL watchdog: got no finish, expected finish before 500000");
    $fatal(1);
  end

  initial begin
    logic [31:0] ra;
    bus.cmd_valid = 1'b0; bus.cmd_addr = 32'h0; bus.cmd_count = 16'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    chk("rst_outputs", 64'({bus.busy, bus.done_valid, bus.m_axi_awvalid, bus.m_axi_wvalid,
                            bus.m_axi_bready, bus.in_ready}), 64'(0));
    chk("rst_aw_fields", 64'({bus.m_axi_awaddr, bus.m_axi_awlen}), 64'(0));
    @(posedge clk); #2;
    rst = 1'b0;
    @(posedge clk); #2;

    issue(32'h1000_0000, 4, -1, 1'b0, 1'b1);  wait_done("single");
    issue(32'h0000_0000, 40, -1, 1'b0, 1'b1); wait_done("three_bursts");
    issue(32'h0000_0FF8, 6, -1, 1'b0, 1'b1);  wait_done("cross_4k");
    issue(32'h0000_0000, 40, 1, 1'b0, 1'b0);  wait_done("slverr");
    issue(32'hFFFF_FFC3, 20, -1, 1'b0, 1'b0); wait_done("addr_wrap");

    rnd_src = 1'b1;
    issue(32'h0000_3000, 12, -1, 1'b0, 1'b0);
    wait_beats(w_seen + 3);
    hold_w_low = 1'b1;
    repeat (5) @(posedge clk);
    #2; hold_w_low = 1'b0;
    wait_done("wready_stall");
    rnd_src = 1'b0;

    issue(32'h2000_0000, 16, -1, 1'b0, 1'b0);
    wait_beats(w_seen + 3);
    rst = 1'b1;
    #1;
    chk("mid_rst_cmd_ready", 64'(bus.cmd_ready), 64'(1));
    chk("mid_rst_outputs", 64'({bus.busy, bus.done_valid, bus.m_axi_awvalid, bus.m_axi_wvalid,
                                bus.m_axi_bready, bus.in_ready}), 64'(0));
    aw_exp.delete(); w_exp.delete(); done_exp.delete(); bresp_q.delete();
    repeat (3) @(posedge clk);
    #2; rst = 1'b0;
    @(posedge clk); #2;
    issue(32'h2000_0100, 2, -1, 1'b0, 1'b1);  wait_done("after_reset");

    issue(32'h0000_0500, 0, -1, 1'b0, 1'b1);  wait_done("zero_count");

    rnd_ready = 1'b1; rnd_src = 1'b1;
    for (int i = 0; i < 25; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 1) == 1) ra[11:0] = 12'(4096 - 4 * $urandom_range(1, 24)) | 12'($urandom_range(0, 3));
      issue(ra, $urandom_range(0, 48), -1, 1'b1, 1'b0);
      wait_done("random");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
